branch_history_table: RTL and testbench

- Table of 2-bit saturating counters that sits directly upstream of the branch predictor in IF.
- Supplies the predictor's 2-bit `state` input for the fetched PC.
- Accepts resolution updates from EX, when a branch's actual direction is known.
- Keeps saturating statistics counters (resolved branches, mispredictions) for performance evaluation.

---
 rtl/branch_history_table.sv | 116 +++++++++++
 tb/tb_branch_history_table.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
// Branch history table: 2-bit saturating direction counters indexed by PC,
// read combinationally in IF and trained by branch resolutions from EX.
// Also keeps saturating counts of resolved branches and mispredictions.
//
// Update handshake: upd_valid is a one-cycle qualifier with no ready; the
// table always accepts. upd_pc/upd_taken/upd_pred are sampled only on an edge
// where upd_valid=1 and are ignored otherwise.
module branch_history_table #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      rd_pc,
    output logic [1:0]       rd_state,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic             upd_pred,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int              ENTRIES = 1 << INDEX_BITS;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Register array rather than RAM so reset can clear every entry at once.
    logic [1:0] table_q [ENTRIES];
    logic [1:0] table_d [ENTRIES];

    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic                  miss_evt;

    // Word-aligned PCs: low two bits never select an entry; high bits alias.
    assign rd_idx  = rd_pc[INDEX_BITS+1:2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc[31:INDEX_BITS+2], rd_pc[1:0],
                              upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

    // Zero-latency read of the registered table; a same-cycle write is not
    // bypassed, so the reader sees the old value until the next cycle.
    assign rd_state = table_q[rd_idx];

    assign miss_evt = upd_valid && (upd_pred != upd_taken);

    // Next table contents: saturating increment/decrement of the updated entry.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            table_d[i] = table_q[i];
        end
        if (upd_valid) begin
            if (upd_taken) begin
                if (table_q[upd_idx] != 2'b11) begin
                    table_d[upd_idx] = table_q[upd_idx] + 2'b01;
                end
            end else begin
                if (table_q[upd_idx] != 2'b00) begin
                    table_d[upd_idx] = table_q[upd_idx] - 2'b01;
                end
            end
        end
    end

    // Next statistics: saturating counters plus the one-cycle miss pulse.
    always_comb begin
        mispredict_d = miss_evt;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (upd_valid && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
        end
        if (miss_evt && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
        end
    end

    // Table state; reset wins over a simultaneous update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    // Statistics state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_q <= 1'b0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign mispredict = mispredict_q;
    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table: a default 32-bit-counter instance
// and a 4-bit-counter instance share the same stimulus.
module tb_branch_history_table;

    logic        clk;
    logic        rst;
    logic [31:0] rd_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred;

    logic [1:0]  rd_state;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    logic [1:0]  rd_state4;
    logic        mispredict4;
    logic [3:0]  branch_cnt4;
    logic [3:0]  miss_cnt4;

    int checks;
    int errors;

    branch_history_table #(.INDEX_BITS(6), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rd_pc(rd_pc), .rd_state(rd_state),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_pred(upd_pred), .mispredict(mispredict),
        .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    branch_history_table #(.INDEX_BITS(6), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .rd_pc(rd_pc), .rd_state(rd_state4),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_pred(upd_pred), .mispredict(mispredict4),
        .branch_cnt(branch_cnt4), .miss_cnt(miss_cnt4)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Combinational read of one PC, sampled 1ns after driving it.
    task automatic read_chk(input string tag, input logic [31:0] pc, input logic [1:0] exp);
        rd_pc = pc;
        #1;
        check(tag, {30'd0, rd_state}, {30'd0, exp});
    endtask

    // One update across one rising edge; returns 1ns after the edge.
    task automatic do_update(input logic [31:0] pc, input logic taken, input logic pred);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
        upd_pred  = pred;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic cnt_chk(input string tag, input logic [31:0] br, input logic [31:0] ms);
        check({tag, "_branch_cnt"}, branch_cnt, br);
        check({tag, "_miss_cnt"}, miss_cnt, ms);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        rd_pc     = 32'h0;
        upd_valid = 1'b0;
        upd_pc    = 32'h0;
        upd_taken = 1'b0;
        upd_pred  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        read_chk("rst_rd_40", 32'h0000_0040, 2'b01);
        read_chk("rst_rd_ffc", 32'h0000_0ffc, 2'b01);
        cnt_chk("rst", 32'd0, 32'd0);
        check("rst_mispredict", {31'd0, mispredict}, 32'd0);
        check("rst_branch_cnt4", {28'd0, branch_cnt4}, 32'd0);

        // Train 0x40 taken: 01 -> 10 -> 11 -> 11; only the first is a miss
        rd_pc = 32'h0000_0040;
        do_update(32'h0000_0040, 1'b1, 1'b0);
        check("train1_mispredict", {31'd0, mispredict}, 32'd1);
        read_chk("train1_rd", 32'h0000_0040, 2'b10);
        do_update(32'h0000_0040, 1'b1, 1'b1);
        check("train2_mispredict", {31'd0, mispredict}, 32'd0);
        read_chk("train2_rd", 32'h0000_0040, 2'b11);
        do_update(32'h0000_0040, 1'b1, 1'b1);
        check("train3_mispredict", {31'd0, mispredict}, 32'd0);
        read_chk("train3_rd", 32'h0000_0040, 2'b11);
        cnt_chk("train", 32'd3, 32'd1);

        // Not-taken on 0x80: 01 -> 00, saturates; neighbour 0x84 untouched
        do_update(32'h0000_0080, 1'b0, 1'b0);
        read_chk("nt1_rd", 32'h0000_0080, 2'b00);
        do_update(32'h0000_0080, 1'b0, 1'b0);
        do_update(32'h0000_0080, 1'b0, 1'b0);
        do_update(32'h0000_0080, 1'b0, 1'b0);
        read_chk("nt4_rd", 32'h0000_0080, 2'b00);
        read_chk("nt_neighbour_84", 32'h0000_0084, 2'b01);
        check("nt_mispredict", {31'd0, mispredict}, 32'd0);
        cnt_chk("nt", 32'd7, 32'd1);

        // Decrement from strongly taken, then back up
        do_update(32'h0000_0040, 1'b0, 1'b1);
        check("dec_mispredict", {31'd0, mispredict}, 32'd1);
        read_chk("dec_rd", 32'h0000_0040, 2'b10);
        do_update(32'h0000_0040, 1'b1, 1'b1);
        read_chk("inc_rd", 32'h0000_0040, 2'b11);
        cnt_chk("decinc", 32'd9, 32'd2);

        // Aliasing: 0xC0 and 0x1C0 share index 48; 0x40 and 0x140 share 16
        do_update(32'h0000_00c0, 1'b1, 1'b0);
        do_update(32'h0000_00c0, 1'b1, 1'b1);
        read_chk("alias_1c0", 32'h0000_01c0, 2'b11);
        read_chk("alias_140", 32'h0000_0140, 2'b11);
        read_chk("alias_c4", 32'h0000_00c4, 2'b01);
        read_chk("alias_low_bits", 32'h0000_00c3, 2'b11);
        cnt_chk("alias", 32'd11, 32'd3);

        // Same-cycle read/write of 0x100: old value now, new value next cycle
        rd_pc     = 32'h0000_0100;
        upd_valid = 1'b1;
        upd_pc    = 32'h0000_0100;
        upd_taken = 1'b1;
        upd_pred  = 1'b0;
        #1;
        check("rdw_old", {30'd0, rd_state}, 32'd1);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        check("rdw_new", {30'd0, rd_state}, 32'd2);
        cnt_chk("rdw", 32'd12, 32'd4);

        // upd_valid=0 ignores the other update fields
        upd_pc    = 32'h0000_0100;
        upd_taken = 1'b0;
        upd_pred  = 1'b1;
        @(posedge clk);
        #1;
        read_chk("idle_rd", 32'h0000_0100, 2'b10);
        check("idle_mispredict", {31'd0, mispredict}, 32'd0);
        cnt_chk("idle", 32'd12, 32'd4);

        // Reset together with an update on a trained entry
        rst = 1'b1;
        do_update(32'h0000_0040, 1'b1, 1'b0);
        rst = 1'b0;
        read_chk("rstupd_rd_40", 32'h0000_0040, 2'b01);
        read_chk("rstupd_rd_80", 32'h0000_0080, 2'b01);
        read_chk("rstupd_rd_c0", 32'h0000_00c0, 2'b01);
        check("rstupd_mispredict", {31'd0, mispredict}, 32'd0);
        cnt_chk("rstupd", 32'd0, 32'd0);
        check("rstupd_branch_cnt4", {28'd0, branch_cnt4}, 32'd0);

        // Counter saturation on the 4-bit build
        for (int i = 0; i < 15; i++) begin
            do_update(32'h0000_0200, 1'b1, 1'b0);
        end
        check("sat15_branch_cnt4", {28'd0, branch_cnt4}, 32'hf);
        check("sat15_miss_cnt4", {28'd0, miss_cnt4}, 32'hf);
        do_update(32'h0000_0200, 1'b1, 1'b0);
        do_update(32'h0000_0200, 1'b1, 1'b0);
        check("sat17_branch_cnt4", {28'd0, branch_cnt4}, 32'hf);
        check("sat17_miss_cnt4", {28'd0, miss_cnt4}, 32'hf);
        check("sat17_mispredict4", {31'd0, mispredict4}, 32'd1);
        cnt_chk("sat17", 32'd17, 32'd17);
        read_chk("sat_rd_200", 32'h0000_0200, 2'b11);
        check("sat_rd_state4", {30'd0, rd_state4}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
